// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush controller with memory-wait watchdog
// Optional HAZARD_PERF_CNT_EN adds stall_cycles/flush_count performance counters.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic [4:0] rd_ex,
  input  logic       mem_read_ex,
  input  logic       branch_taken_ex,
  input  logic       dmem_req_mem,
  input  logic       dmem_ack_mem,
  output logic       pc_write_en,
  output logic       if_id_write_en,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       ex_mem_hold,
  output logic       timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic RUN      = 1'b0;
  localparam logic MEM_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic             state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic load_use;
  logic mem_stall;
  logic flush_req;
  logic flush_active;

  assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                    ((use_rs1_id && (rs1_id == rd_ex)) ||
                     (use_rs2_id && (rs2_id == rd_ex)));
  assign mem_stall    = dmem_req_mem && !dmem_ack_mem;
  assign flush_req    = branch_taken_ex || flush_pend_q;
  assign flush_active = !mem_stall && flush_req;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= RUN;
      flush_pend_q  <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_pend_q  <= flush_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_stall) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ack_mem || !dmem_req_mem) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // A branch resolved during a freeze is remembered and applied on the first free cycle.
  always_comb begin
    flush_pend_d = flush_pend_q;
    if (mem_stall && branch_taken_ex) begin
      flush_pend_d = 1'b1;
    end else if (flush_active) begin
      flush_pend_d = 1'b0;
    end

    wait_cnt_d = wait_cnt_q;
    if (!mem_stall) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    timeout_err_d = timeout_err_q || (mem_stall && (wait_cnt_q == CNT_LAST));
  end

  always_comb begin
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_hold    = 1'b0;
    if (arst_n) begin
      if (mem_stall) begin
        ex_mem_hold = 1'b1;
      end else if (flush_req) begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b1;
        id_ex_bubble   = 1'b1;
      end else if (load_use) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic        stall_event;

  assign stall_event = mem_stall || (load_use && !flush_req);

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_event};
    flush_count_d  = flush_count_q + {31'd0, flush_active};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       use_rs1_id, use_rs2_id, mem_read_ex, branch_taken_ex;
  logic       dmem_req_mem, dmem_ack_mem;
  logic       pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_hold, timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .arst_n(arst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ack_mem(dmem_ack_mem),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold), .timeout_err(timeout_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected vector: {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_hold, timeout_err}
  localparam logic [5:0] OFF  = 6'b000000;
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] LU   = 6'b000100;
  localparam logic [5:0] HOLD = 6'b000010;
  localparam logic [5:0] FL   = 6'b111100;

  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  task automatic check(input string tag);
    logic [5:0] e, o;
    e = exp_q.pop_front();
    o = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_hold, timeout_err};
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic step(input logic [5:0] e, input string tag);
    exp_q.push_back(e);
    #2;
    check(tag);
    if (arst_n) begin
      if (e[1] || (e[2] && !e[3])) exp_stall++;
      if (e[3]) exp_flush++;
    end
    @(negedge clk);
  endtask

  task automatic check_state(input logic s, input string tag);
    n_checks++;
    assert (dut.state_q === s) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, dut.state_q, s);
    end
  endtask

  task automatic idle();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0; mem_read_ex = 1'b0;
    branch_taken_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ack_mem = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0;
    idle();
    @(negedge clk);
    step(OFF, "reset_held");
    arst_n = 1'b1;
    step(NORM, "reset_release");

    mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; use_rs1_id = 1'b1;
    step(LU, "load_use_rs1");
    mem_read_ex = 1'b0;
    step(NORM, "load_use_done");

    idle(); mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; use_rs2_id = 1'b1;
    step(LU, "load_use_rs2");
    use_rs2_id = 1'b0;
    step(NORM, "rs2_unused");
    idle(); mem_read_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; use_rs1_id = 1'b1;
    step(NORM, "x0_no_stall");

    idle(); dmem_req_mem = 1'b1;
    step(HOLD, "mem_wait_1");
    check_state(1'b1, "state_mem_wait");
    step(HOLD, "mem_wait_2");
    step(HOLD, "mem_wait_3");
    dmem_ack_mem = 1'b1;
    step(NORM, "mem_ack");
    check_state(1'b0, "state_run_after_ack");
    idle();
    step(NORM, "mem_idle");

    dmem_req_mem = 1'b1; dmem_ack_mem = 1'b1;
    step(NORM, "ack_first_cycle");
    check_state(1'b0, "state_run_fast_ack");

    idle(); dmem_req_mem = 1'b1; branch_taken_ex = 1'b1;
    step(HOLD, "branch_in_wait");
    branch_taken_ex = 1'b0;
    step(HOLD, "wait_pending");
    dmem_ack_mem = 1'b1;
    step(FL, "pending_flush");
    idle();
    step(NORM, "flush_once");

    dmem_req_mem = 1'b1; branch_taken_ex = 1'b1;
    step(HOLD, "branch_in_wait_b");
    dmem_ack_mem = 1'b1;
    step(FL, "pend_and_new_branch");
    idle();
    step(NORM, "single_flush");

    branch_taken_ex = 1'b1; mem_read_ex = 1'b1; rd_ex = 5'd3; rs1_id = 5'd3; use_rs1_id = 1'b1;
    step(FL, "branch_over_load_use");
    idle();
    step(NORM, "after_priority");

    dmem_req_mem = 1'b1;
    step(HOLD, "wd_1");
    step(HOLD, "wd_2");
    step(HOLD, "wd_3");
    step(HOLD, "wd_4");
    step(HOLD | 6'b000001, "wd_timeout");
    dmem_ack_mem = 1'b1;
    step(NORM | 6'b000001, "wd_sticky_ack");
    idle();
    step(NORM | 6'b000001, "wd_sticky_idle");

    dmem_req_mem = 1'b1; branch_taken_ex = 1'b1;
    step(HOLD | 6'b000001, "stall_before_reset");
    branch_taken_ex = 1'b0;
    #2;
    arst_n = 1'b0;
    #1;
    exp_q.push_back(OFF);
    check("async_reset_mid_cycle");
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    arst_n = 1'b1;
    idle();
    step(NORM, "restart_no_flush");

`ifdef HAZARD_PERF_CNT_EN
    idle(); mem_read_ex = 1'b1; rd_ex = 5'd9; rs2_id = 5'd9; use_rs2_id = 1'b1;
    step(LU, "perf_lu");
    idle(); dmem_req_mem = 1'b1; branch_taken_ex = 1'b1;
    step(HOLD, "perf_hold");
    idle();
    step(FL, "perf_flush");
    n_checks++;
    assert (stall_cycles === 32'(exp_stall)) else begin
      n_fail++;
      $error("FAIL stall_cycles observed=%0d expected=%0d", stall_cycles, exp_stall);
    end
    n_checks++;
    assert (flush_count === 32'(exp_flush)) else begin
      n_fail++;
      $error("FAIL flush_count observed=%0d expected=%0d", flush_count, exp_flush);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
